// File: rtl/spi_reg_config.sv
// SPI mode-0 write-only configuration target. The asynchronous SCLK/COPI/nCS
// pins are brought into the clk domain, 16-bit frames are assembled and each
// valid write lands in one of five 8-bit PWM configuration registers.
//
// Frame: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data, MSB first.
// Handshake: the block has no valid/ready interface. wr_pulse and err_pulse are
// one-cycle strobes that are high only in the COMMIT state, and each frame
// produces exactly one of them. The FSM state is held in `state` (state_t).
module spi_reg_config #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_pulse,
    output logic       err_pulse
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [4:0] FRAME_BITS = 5'd16;
    localparam logic [4:0] OVERRUN    = 5'd17;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] copi_sync;
    logic [SYNC_STAGES-1:0] ncs_sync;
    logic                   sclk_hist;
    logic                   ncs_hist;
    // Shifts in ones after reset; its MSB says the synchroniser and history
    // flops now hold real pin samples instead of their reset values.
    logic [SYNC_STAGES:0]   fill;

    logic sclk_s, copi_s, ncs_s, sync_ok;
    logic sclk_rise, ncs_fall, ncs_rise;

    state_t      state, state_next;
    logic [4:0]  bit_cnt, bit_cnt_next;
    logic [15:0] shift_reg, shift_next;
    logic        armed, armed_next;
    logic        commit_ok;

    // Synchronise the three pins and keep one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '1;
            sclk_hist <= 1'b0;
            ncs_hist  <= 1'b1;
            fill      <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            sclk_hist <= sclk_sync[SYNC_STAGES-1];
            ncs_hist  <= ncs_sync[SYNC_STAGES-1];
            fill      <= {fill[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sclk_s  = sclk_sync[SYNC_STAGES-1];
    assign copi_s  = copi_sync[SYNC_STAGES-1];
    assign ncs_s   = ncs_sync[SYNC_STAGES-1];
    assign sync_ok = fill[SYNC_STAGES];

    // Edges are suppressed until the pipeline has refilled after reset, so a
    // chip select that was already low at reset release is not seen as a fall.
    assign sclk_rise = sync_ok &  sclk_s & ~sclk_hist;
    assign ncs_fall  = sync_ok & ~ncs_s  &  ncs_hist;
    assign ncs_rise  = sync_ok &  ncs_s  & ~ncs_hist;

    assign commit_ok = (bit_cnt == FRAME_BITS) && shift_reg[15] &&
                       (shift_reg[14:8] <= MAX_ADDR);

    // FSM state, bit counter, shift register and armed flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            armed     <= 1'b0;
        end else begin
            state     <= state_next;
            bit_cnt   <= bit_cnt_next;
            shift_reg <= shift_next;
            armed     <= armed_next;
        end
    end

    // Next-state logic and the commit/error strobes.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shift_next   = shift_reg;
        armed_next   = armed;
        wr_pulse     = 1'b0;
        err_pulse    = 1'b0;
        case (state)
            IDLE: begin
                if (ncs_fall) begin
                    bit_cnt_next = '0;
                    shift_next   = '0;
                    armed_next   = 1'b1;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                // A chip-select rise wins over an SCLK edge in the same cycle.
                if (ncs_rise) begin
                    state_next = COMMIT;
                end else if (armed && sclk_rise && !ncs_s) begin
                    shift_next = {shift_reg[14:0], copi_s};
                    if (bit_cnt != OVERRUN) begin
                        bit_cnt_next = bit_cnt + 5'd1;
                    end
                end
            end
            COMMIT: begin
                if (commit_ok) begin
                    wr_pulse = 1'b1;
                end else begin
                    err_pulse = 1'b1;
                end
                armed_next = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Configuration registers, written on the clk edge that ends COMMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
        end else if (wr_pulse) begin
            case (shift_reg[14:8])
                7'h00:   en_reg_out_7_0  <= shift_reg[7:0];
                7'h01:   en_reg_out_15_8 <= shift_reg[7:0];
                7'h02:   en_reg_pwm_7_0  <= shift_reg[7:0];
                7'h03:   en_reg_pwm_15_8 <= shift_reg[7:0];
                7'h04:   pwm_duty_cycle  <= shift_reg[7:0];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_config.sv
// Directed bench for spi_reg_config: a vector table of SPI frames with
// hand-computed register images, plus hand-written reset and edge-collision
// sequences. Register image order: {out_7_0, out_15_8, pwm_7_0, pwm_15_8, duty}.
module tb_spi_reg_config;
    localparam int SYNC_STAGES = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       copi = 1'b0;
    logic       ncs = 1'b1;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_pulse, err_pulse;
    logic [39:0] regs_now;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    int err_cnt = 0;

    logic [39:0] exp_q[$];

    typedef struct {
        string       name;
        logic [16:0] bits;
        int          nbits;
        logic [39:0] exp_regs;
        int          exp_wr;
        int          exp_err;
    } vec_t;

    vec_t vecs[11];

    spi_reg_config #(.SYNC_STAGES(SYNC_STAGES), .MAX_ADDR(7'h04)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sclk(sclk),
        .copi(copi),
        .ncs(ncs),
        .en_reg_out_7_0(en_reg_out_7_0),
        .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0),
        .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle),
        .wr_pulse(wr_pulse),
        .err_pulse(err_pulse)
    );

    assign regs_now = {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
                       en_reg_pwm_15_8, pwm_duty_cycle};

    // Clock and safety timeout.
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    // Pulse monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (wr_pulse) wr_cnt++;
        if (err_pulse) err_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // SPI driver: SCLK = clk/8, data changes while SCLK is low.
    task automatic start_frame();
        ncs = 1'b0;
        wait_clk(4);
    endtask

    task automatic shift_bits(input logic [16:0] bits, input int nbits);
        for (int b = nbits - 1; b >= 0; b--) begin
            copi = bits[b];
            wait_clk(4);
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
        end
    endtask

    task automatic apply(input string name, input logic [16:0] bits, input int nbits,
                         input int exp_wr, input int exp_err, input bit meas_lat);
        int wr0, err0, lat;
        logic [39:0] exp_regs;
        exp_regs = exp_q.pop_front();
        wr0 = wr_cnt;
        err0 = err_cnt;
        start_frame();
        shift_bits(bits, nbits);
        copi = 1'b0;
        wait_clk(4);
        ncs = 1'b1;
        if (meas_lat) begin
            lat = 0;
            while (regs_now !== exp_regs && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            check({name, "_latency"}, 64'(lat <= SYNC_STAGES + 2), 64'd1);
        end
        wait_clk(12);
        check({name, "_regs"}, 64'(regs_now), 64'(exp_regs));
        check({name, "_wr"}, 64'(wr_cnt - wr0), 64'(exp_wr));
        check({name, "_err"}, 64'(err_cnt - err0), 64'(exp_err));
    endtask

    // Stimulus and checking.
    initial begin
        int wr0, err0;
        vecs[0]  = '{"wr_a0_f0",   17'h080F0, 16, 40'hF0_00_00_00_00, 1, 0};
        vecs[1]  = '{"wr_a0_ff",   17'h080FF, 16, 40'hFF_00_00_00_00, 1, 0};
        vecs[2]  = '{"wr_a1_0f",   17'h0810F, 16, 40'hFF_0F_00_00_00, 1, 0};
        vecs[3]  = '{"wr_a2_a5",   17'h082A5, 16, 40'hFF_0F_A5_00_00, 1, 0};
        vecs[4]  = '{"wr_a3_5a",   17'h0835A, 16, 40'hFF_0F_A5_5A_00, 1, 0};
        vecs[5]  = '{"wr_a4_80",   17'h08480, 16, 40'hFF_0F_A5_5A_80, 1, 0};
        vecs[6]  = '{"bad_addr5",  17'h08511, 16, 40'hFF_0F_A5_5A_80, 0, 1};
        vecs[7]  = '{"read_frame", 17'h00012, 16, 40'hFF_0F_A5_5A_80, 0, 1};
        vecs[8]  = '{"short_15",   17'h04208, 15, 40'hFF_0F_A5_5A_80, 0, 1};
        vecs[9]  = '{"overrun_17", 17'h108AB, 17, 40'hFF_0F_A5_5A_80, 0, 1};
        vecs[10] = '{"rewrite_a4", 17'h08480, 16, 40'hFF_0F_A5_5A_80, 1, 0};

        // Reset held for 5 clk.
        rst_n = 1'b0;
        wait_clk(5);
        check("reset_regs", 64'(regs_now), 64'd0);
        check("reset_wr_pulse", 64'(wr_pulse), 64'd0);
        check("reset_err_pulse", 64'(err_pulse), 64'd0);
        rst_n = 1'b1;
        wait_clk(20);
        check("idle_regs", 64'(regs_now), 64'd0);
        check("idle_pulses", 64'(wr_cnt + err_cnt), 64'd0);

        // Table-driven frames.
        foreach (vecs[i]) exp_q.push_back(vecs[i].exp_regs);
        foreach (vecs[i]) begin
            apply(vecs[i].name, vecs[i].bits, vecs[i].nbits,
                  vecs[i].exp_wr, vecs[i].exp_err, i == 0);
            wait_clk(6);
        end

        // Reset after 8 bits of a write to 0x04, released with ncs still low.
        start_frame();
        shift_bits(17'h00084, 8);
        rst_n = 1'b0;
        wait_clk(5);
        check("midreset_regs", 64'(regs_now), 64'd0);
        check("midreset_pulses", 64'({wr_pulse, err_pulse}), 64'd0);
        rst_n = 1'b1;
        wr0 = wr_cnt;
        err0 = err_cnt;
        shift_bits(17'h00077, 8);
        copi = 1'b0;
        wait_clk(4);
        ncs = 1'b1;
        wait_clk(12);
        check("midreset_duty", 64'(pwm_duty_cycle), 64'h00);
        check("midreset_no_wr", 64'(wr_cnt - wr0), 64'd0);
        check("midreset_no_err", 64'(err_cnt - err0), 64'd0);

        // Fresh frame after the aborted one.
        exp_q.push_back(40'h00_00_00_00_40);
        apply("after_reset_a4_40", 17'h08440, 16, 1, 0, 1'b1);
        wait_clk(6);

        // Extra SCLK rise coincident with ncs rise after 16 good bits.
        exp_q.push_back(40'h00_00_33_00_40);
        wr0 = wr_cnt;
        err0 = err_cnt;
        start_frame();
        shift_bits(17'h08233, 16);
        copi = 1'b1;
        wait_clk(4);
        sclk = 1'b1;
        ncs = 1'b1;
        wait_clk(4);
        sclk = 1'b0;
        wait_clk(8);
        check("coincident_regs", 64'(regs_now), 64'(exp_q.pop_front()));
        check("coincident_wr", 64'(wr_cnt - wr0), 64'd1);
        check("coincident_err", 64'(err_cnt - err0), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
